bram_capture_ctrl: RTL and testbench

- Controller that sits directly in front of a single-port synchronous-read bram (WordLengthBits/NumWords/AddressWidthBits).
- On a start pulse, writes CaptureLength consecutive valid input samples into bram addresses 0..CaptureLength-1.
- Then reads them back in address order and presents them on a ready/valid output stream.
- Used for snapshot capture of a sample stream, e.g. debug capture of ADC or DSP samples, for later slow readout.

---
 rtl/bram_capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bram_capture_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl
// -----------------
// Snapshot capture controller placed directly in front of a single-port,
// synchronous-read block RAM. A start pulse arms a capture of CaptureLength
// valid input samples into bram addresses 0..CaptureLength-1. The controller
// then reads those samples back in address order and presents them on a
// ready/valid output stream. A typical use is debug capture of ADC or DSP
// samples for slow readout later.
//
// Ports:
//   clk                - system clock, all logic on the rising edge
//   rst                - synchronous active-high reset
//   start              - begin a capture (only looked at while idle)
//   in_data/in_valid   - input sample stream, no backpressure
//   out_data/out_valid - readout stream towards the consumer
//   out_ready          - consumer accepts out_data when out_valid is high
//   busy               - high whenever the controller is not idle
//   done               - one-cycle pulse after the final readout handshake
//   bram_address       - address to the bram
//   bram_write_enable  - write strobe to the bram
//   bram_data_in       - write data to the bram
//   bram_data_out      - bram read data, valid one clock after the address

module bram_capture_ctrl #(
    parameter int WordLengthBits   = 8,
    parameter int NumWords         = 128,
    parameter int AddressWidthBits = 7,
    parameter int CaptureLength    = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WordLengthBits-1:0]   in_data,
    input  logic                        in_valid,
    output logic [WordLengthBits-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic [AddressWidthBits-1:0] bram_address,
    output logic                        bram_write_enable,
    output logic [WordLengthBits-1:0]   bram_data_in,
    input  logic [WordLengthBits-1:0]   bram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        READ_ADDR,
        READ_LATCH,
        OUTPUT
    } state_t;

    // The capture length can never exceed the bram depth, so the last
    // address is clamped to the top word. The pointers therefore stop at
    // the top address and never wrap.
    localparam int CaptureLimit = (CaptureLength < NumWords) ? CaptureLength : NumWords;
    localparam logic [AddressWidthBits-1:0] LastAddress = AddressWidthBits'(CaptureLimit - 1);
    localparam logic [AddressWidthBits-1:0] AddressOne  = AddressWidthBits'(1);
    localparam logic [AddressWidthBits-1:0] AddressZero = '0;

    state_t                      state,          state_next;
    logic [AddressWidthBits-1:0] wr_ptr,         wr_ptr_next;
    logic [AddressWidthBits-1:0] rd_ptr,         rd_ptr_next;
    logic [WordLengthBits-1:0]   out_data_reg,   out_data_next;
    logic                        out_valid_reg,  out_valid_next;
    logic                        done_reg,       done_next;

    // State register together with every registered output. Reset wins over
    // everything and aborts a capture or readout on the spot. The bram
    // contents are left alone, which is harmless because the next capture
    // overwrites from address 0 before anything is read back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= AddressZero;
            rd_ptr        <= AddressZero;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state         <= state_next;
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic. Each readout word passes through READ_ADDR, which
    // presents rd_ptr to the bram, and READ_LATCH, where the synchronous read
    // data has arrived. The word is then held in OUTPUT until the consumer
    // takes it. This gives at most one word per three clocks, which is
    // plenty for snapshot readout and keeps the datapath trivial.
    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = CAPTURE;
                    wr_ptr_next = AddressZero;
                end
            end

            CAPTURE: begin
                if (in_valid) begin
                    if (wr_ptr == LastAddress) begin
                        state_next  = READ_ADDR;
                        rd_ptr_next = AddressZero;
                    end else begin
                        wr_ptr_next = wr_ptr + AddressOne;
                    end
                end
            end

            READ_ADDR: begin
                state_next = READ_LATCH;
            end

            READ_LATCH: begin
                out_data_next  = bram_data_out;
                out_valid_next = 1'b1;
                state_next     = OUTPUT;
            end

            OUTPUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (rd_ptr == LastAddress) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rd_ptr_next = rd_ptr + AddressOne;
                        state_next  = READ_ADDR;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The bram port is driven straight from state and the live input, so an
    // input sample is written in the same cycle that it arrives.
    always_comb begin
        bram_address      = (state == CAPTURE) ? wr_ptr : rd_ptr;
        bram_write_enable = (state == CAPTURE) && in_valid;
        bram_data_in      = in_data;
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl
// --------------------
// Bench for bram_capture_ctrl. It drives two instances, each with its own
// bram model:
//   dut  - the default 128-word capture
//   dut1 - a CaptureLength=1 build
// dut1 is driven from a cycle-by-cycle vector table. dut runs whole snapshot
// transactions against a queue-based reference model of the capture and
// readout rules.

module tb_bram_capture_ctrl;

    localparam int Cap = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [6:0] bram_address;
    logic       bram_write_enable;
    logic [7:0] bram_data_in;
    logic [7:0] bram_data_out;

    logic       start1 = 1'b0;
    logic       in_valid1 = 1'b0;
    logic [7:0] in_data1 = 8'h00;
    logic       out_ready1 = 1'b0;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       busy1;
    logic       done1;
    logic [6:0] bram_address1;
    logic       bram_write_enable1;
    logic [7:0] bram_data_in1;
    logic [7:0] bram_data_out1;

    logic [7:0] mem0 [0:127];
    logic [7:0] mem1 [0:127];

    int vectors = 0;
    int miscompares = 0;

    bram_capture_ctrl #(
        .WordLengthBits(8), .NumWords(128), .AddressWidthBits(7), .CaptureLength(Cap)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .bram_address(bram_address),
        .bram_write_enable(bram_write_enable), .bram_data_in(bram_data_in),
        .bram_data_out(bram_data_out)
    );

    bram_capture_ctrl #(
        .WordLengthBits(8), .NumWords(128), .AddressWidthBits(7), .CaptureLength(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(in_data1), .in_valid(in_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .done(done1), .bram_address(bram_address1),
        .bram_write_enable(bram_write_enable1), .bram_data_in(bram_data_in1),
        .bram_data_out(bram_data_out1)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read bram models with read-before-write behaviour.
    always @(posedge clk) begin
        if (bram_write_enable) mem0[bram_address] <= bram_data_in;
        bram_data_out <= mem0[bram_address];
    end

    always @(posedge clk) begin
        if (bram_write_enable1) mem1[bram_address1] <= bram_data_in1;
        bram_data_out1 <= mem1[bram_address1];
    end

    // Last-resort guard so that the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d, input logic r);
        start     = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Run one complete snapshot on dut.
    //   validMode: 0 = always valid, 1 = pattern 1,0,0, 2 = random
    //   readyMode: 0 = always ready, 1 = random, 2 = stall 10 cycles on word 5
    //   dataMode:  0 = index n, 1 = 8'hA0+n, 2 = 8'hFF, 3 = random
    //   abortAt:   reset while word abortAt is presented, or -1 for no abort
    // The model captures the first Cap valid samples after the start cycle.
    // It then expects each word to appear three clocks after the previous
    // handshake (or after the last write), held until accepted, and done one
    // clock after the final handshake.
    task automatic runSnapshot(input string tag, input int validMode, input int readyMode,
                               input int dataMode, input bit startNoise, input int abortAt);
        logic [7:0] expected [$];
        int   captured;
        int   handshakes;
        int   cycle;
        int   finalCycle;
        int   lastWriteCycle;
        int   lastHsCycle;
        int   stallCount;
        int   readyAt;
        bit   finished;
        bit   capturing;
        bit   reading;
        bit   expOv;
        logic v, r, s;
        logic [7:0] d;

        captured = 0; handshakes = 0; cycle = 0; finalCycle = -1;
        lastWriteCycle = -1; lastHsCycle = -1; stallCount = 0; finished = 1'b0;

        nextCycle();
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1);
        #1;
        checkOutput({tag, " start-cycle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " start-cycle write_enable"}, 32'(bram_write_enable), 32'd0);

        while (!finished) begin
            nextCycle();
            cycle++;
            capturing = (captured < Cap);
            reading   = !capturing && (handshakes < Cap);
            readyAt   = ((handshakes == 0) ? lastWriteCycle : lastHsCycle) + 3;

            if (cycle > 6000) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s timeout: %0d words read, required %0d", tag, handshakes, Cap);
                finished = 1'b1;
            end else if (abortAt >= 0 && reading && handshakes == abortAt && cycle >= readyAt) begin
                applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
                rst = 1'b1;
                nextCycle();
                rst = 1'b0;
                applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
                #1;
                checkOutput({tag, " abort out_valid"}, 32'(out_valid), 32'd0);
                checkOutput({tag, " abort busy"}, 32'(busy), 32'd0);
                checkOutput({tag, " abort write_enable"}, 32'(bram_write_enable), 32'd0);
                checkOutput({tag, " abort done"}, 32'(done), 32'd0);
                checkOutput({tag, " abort out_data"}, 32'(out_data), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    nextCycle();
                    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
                    #1;
                    checkOutput({tag, " post-abort done"}, 32'(done), 32'd0);
                    checkOutput({tag, " post-abort busy"}, 32'(busy), 32'd0);
                end
                finished = 1'b1;
            end else begin
                case (validMode)
                    0:       v = 1'b1;
                    1:       v = (cycle % 3 == 1);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (v) begin
                    case (dataMode)
                        0:       d = 8'(captured);
                        1:       d = 8'(8'hA0 + captured);
                        2:       d = 8'hFF;
                        default: d = 8'($urandom_range(0, 255));
                    endcase
                end else begin
                    d = (dataMode == 3) ? 8'($urandom_range(0, 255)) : 8'h55;
                end
                case (readyMode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = !(handshakes == 5 && stallCount < 10);
                endcase
                s = (startNoise && (capturing || reading)) ? 1'($urandom_range(0, 1)) : 1'b0;

                applyStimulus(s, v, d, r);
                #1;

                checkOutput({tag, " busy"}, 32'(busy), 32'(capturing || reading));
                checkOutput({tag, " done"}, 32'(done), 32'(finalCycle >= 0 && cycle == finalCycle + 1));
                checkOutput({tag, " write_enable"}, 32'(bram_write_enable), 32'(capturing && v));
                if (capturing)
                    checkOutput({tag, " capture address"}, 32'(bram_address), 32'(captured));
                if (reading)
                    checkOutput({tag, " read address"}, 32'(bram_address), 32'(handshakes));

                if (capturing && v) begin
                    expected.push_back(d);
                    captured++;
                    if (captured == Cap) lastWriteCycle = cycle;
                end

                if (reading) begin
                    expOv = (cycle >= readyAt);
                    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(expOv));
                    if (expOv) begin
                        checkOutput({tag, " out_data"}, 32'(out_data), 32'(expected[0]));
                        if (r) begin
                            void'(expected.pop_front());
                            handshakes++;
                            lastHsCycle = cycle;
                            if (handshakes == Cap) finalCycle = cycle;
                        end else begin
                            stallCount++;
                        end
                    end
                end else if (!capturing) begin
                    checkOutput({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
                    if (cycle >= finalCycle + 3) finished = 1'b1;
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic       start;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_busy;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_done;
        logic       exp_we;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic r,
                                logic eb, logic ev, logic [7:0] ed, logic edn, logic ew);
        vec_t t;
        t.start = s; t.in_valid = v; t.in_data = d; t.out_ready = r;
        t.exp_busy = eb; t.exp_valid = ev; t.exp_data = ed; t.exp_done = edn; t.exp_we = ew;
        return t;
    endfunction

    initial begin
        vec_t tbl [15];

        // CaptureLength=1 sequence: in_valid ignored while idle, one write of
        // 8'h3C, readout with a one-cycle stall, done, then a restart accepted
        // in the same cycle as done with out_ready ignored before out_valid.
        tbl[0]  = mk(1'b0, 1'b1, 8'h11, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 8'h3C, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 8'h77, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 8'h5A, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset with start and in_valid active: both must be overridden.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h42, 1'b1);
        start1 = 1'b1; in_valid1 = 1'b1;
        repeat (3) nextCycle();
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset write_enable", 32'(bram_write_enable), 32'd0);
        checkOutput("reset address", 32'(bram_address), 32'd0);
        checkOutput("reset busy (len1)", 32'(busy1), 32'd0);
        checkOutput("reset out_valid (len1)", 32'(out_valid1), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        start1 = 1'b0; in_valid1 = 1'b0;

        $display("[TB] CaptureLength=1 vector table");
        for (int i = 0; i < 15; i++) begin
            nextCycle();
            start1 = tbl[i].start; in_valid1 = tbl[i].in_valid;
            in_data1 = tbl[i].in_data; out_ready1 = tbl[i].out_ready;
            #1;
            checkOutput($sformatf("len1 v%0d busy", i), 32'(busy1), 32'(tbl[i].exp_busy));
            checkOutput($sformatf("len1 v%0d out_valid", i), 32'(out_valid1), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("len1 v%0d done", i), 32'(done1), 32'(tbl[i].exp_done));
            checkOutput($sformatf("len1 v%0d write_enable", i), 32'(bram_write_enable1), 32'(tbl[i].exp_we));
            checkOutput($sformatf("len1 v%0d address", i), 32'(bram_address1), 32'd0);
            if (tbl[i].exp_valid)
                checkOutput($sformatf("len1 v%0d out_data", i), 32'(out_data1), 32'(tbl[i].exp_data));
        end

        $display("[TB] full-rate capture and readout");
        runSnapshot("seq", 0, 0, 0, 1'b0, -1);
        $display("[TB] gapped capture");
        runSnapshot("gaps", 1, 0, 1, 1'b0, -1);
        $display("[TB] readout stall");
        runSnapshot("stall", 0, 2, 0, 1'b0, -1);
        $display("[TB] start noise while busy");
        runSnapshot("noise", 0, 1, 0, 1'b1, -1);
        $display("[TB] reset during readout");
        runSnapshot("abort", 0, 0, 0, 1'b0, 40);
        $display("[TB] capture after abort");
        runSnapshot("ff", 0, 0, 2, 1'b0, -1);
        for (int n = 0; n < 3; n++) begin
            $display("[TB] random snapshot %0d", n);
            runSnapshot($sformatf("rand%0d", n), 2, 1, 3, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
